// File: rtl/lcd_scanout_pkg.sv
// rtl/lcd_scanout_pkg.sv - shared FSM encoding and pixel constants for LCD framebuffer scanout
package lcd_scanout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ABORT = 3'd4
  } scan_state_t;

  localparam int PIXEL_W = 24;
  localparam logic [PIXEL_W-1:0] UNDERFLOW_COLOR = 24'hFF00FF;

endpackage

// File: rtl/lcd_pixel_fifo.sv
// rtl/lcd_pixel_fifo.sv - synchronous pixel FIFO with flush; head reads as zero when empty
module lcd_pixel_fifo
  import lcd_scanout_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               push,
  input  logic [PIXEL_W-1:0] push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [PIXEL_W-1:0] head,
  output logic [CW-1:0]      count,
  output logic               empty,
  output logic               full
);

  localparam int AW = $clog2(DEPTH);

  logic [PIXEL_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               wr_en;
  logic               rd_en;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  // A pop on empty is ignored, so a same-cycle push into an empty FIFO is retained.
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign head  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  // The read credit scheme upstream must never let a beat arrive into a full FIFO.
  always @(posedge clock) begin
    if (reset_n && push && !flush) assert (!full);
  end

endmodule

// File: rtl/lcd_fb_scanout_ctrl.sv
// rtl/lcd_fb_scanout_ctrl.sv - framebuffer scanout: burst reads, line FIFO, frame-boundary buffer swap
// Optional LCD_SCANOUT_UNDERFLOW_COUNT_EN adds underflow_count and magenta fill on underflow.
module lcd_fb_scanout_ctrl
  import lcd_scanout_pkg::*;
#(
  parameter int WIDTH      = 800,
  parameter int HEIGHT     = 480,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               next_frame,
  input  logic [31:0]        fb_base,
  input  logic               swap_req,
  output logic               swap_ack,
  output logic [31:0]        rd_address,
  output logic [7:0]         rd_burstcount,
  output logic               rd_read,
  input  logic               rd_waitrequest,
  input  logic [31:0]        rd_readdata,
  input  logic               rd_readdatavalid,
  input  logic               pix_pop,
  output logic [PIXEL_W-1:0] pix_data,
  output logic               underflow
`ifdef LCD_SCANOUT_UNDERFLOW_COUNT_EN
  ,
  output logic [15:0]        underflow_count
`endif
);

  localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] TOTAL_W     = 32'(WIDTH * HEIGHT);
  localparam logic [31:0] BURST_W     = 32'(BURST_LEN);
  localparam logic [31:0] BURST_BYTES = 32'(4 * BURST_LEN);

  scan_state_t        state;
  logic [31:0]        front_base;
  logic [31:0]        pending_base;
  logic               pending;
  logic [31:0]        addr;
  logic [31:0]        word_cnt;
  logic [CW-1:0]      outstanding;
  logic [CW-1:0]      fifo_count;
  logic               fifo_empty;
  logic               fifo_full;
  logic [PIXEL_W-1:0] fifo_head;
  logic [31:0]        free_credit;
  logic               accept;
  logic               push;
  logic               flush;
  logic               pop_empty;
  logic [8:0]         unused_bits;

  // Reserve FIFO space for every word already requested, so a burst can never overflow it.
  assign free_credit   = 32'(FIFO_DEPTH) - 32'(fifo_count) - 32'(outstanding);
  assign rd_read       = (state == ST_FETCH) && (free_credit >= BURST_W);
  assign accept        = rd_read & ~rd_waitrequest;
  assign rd_address    = addr;
  assign rd_burstcount = (state == ST_FETCH) ? 8'(BURST_LEN) : 8'd0;
  assign swap_ack      = (state == ST_START) && pending;
  assign push          = rd_readdatavalid && (state != ST_ABORT);
  assign flush         = (state == ST_START);
  assign pop_empty     = pix_pop & fifo_empty;
  assign unused_bits   = {rd_readdata[31:24], fifo_full};

  lcd_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (rd_readdata[PIXEL_W-1:0]),
    .pop       (pix_pop),
    .flush     (flush),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding
                   + (accept ? CW'(BURST_LEN) : CW'(0))
                   - (rd_readdatavalid ? CW'(1) : CW'(0));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      front_base   <= '0;
      pending_base <= '0;
      pending      <= 1'b0;
      addr         <= '0;
      word_cnt     <= '0;
      underflow    <= 1'b0;
    end else begin
      if (pop_empty) underflow <= 1'b1;
      if (swap_req) begin
        pending_base <= fb_base;
        pending      <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (next_frame) state <= ST_START;
        end
        ST_START: begin
          // A request arriving in this same cycle stays pending for the following frame.
          if (pending) begin
            front_base <= pending_base;
            addr       <= pending_base;
            if (!swap_req) pending <= 1'b0;
          end else begin
            addr <= front_base;
          end
          word_cnt  <= '0;
          underflow <= 1'b0;
          state     <= ST_FETCH;
        end
        ST_FETCH: begin
          if (accept) begin
            addr     <= addr + BURST_BYTES;
            word_cnt <= word_cnt + BURST_W;
          end
          if (next_frame) state <= ST_ABORT;
          else if (accept && (word_cnt + BURST_W == TOTAL_W)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (next_frame) state <= ST_ABORT;
          else if (outstanding == '0) state <= ST_IDLE;
        end
        ST_ABORT: begin
          if (outstanding == '0) state <= ST_START;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LCD_SCANOUT_UNDERFLOW_COUNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      underflow_count <= '0;
    end else if (state == ST_START) begin
      underflow_count <= '0;
    end else if (pop_empty && (underflow_count != 16'hFFFF)) begin
      underflow_count <= underflow_count + 16'd1;
    end
  end

  assign pix_data = pop_empty ? UNDERFLOW_COLOR : fifo_head;
`else
  assign pix_data = fifo_head;
`endif

endmodule

// File: tb/tb_lcd_fb_scanout_ctrl.sv
// tb/tb_lcd_fb_scanout_ctrl.sv - directed self-checking bench for lcd_fb_scanout_ctrl (8x2, burst 4, depth 8)
module tb_lcd_fb_scanout_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        next_frame = 1'b0;
  logic [31:0] fb_base = '0;
  logic        swap_req = 1'b0;
  logic        swap_ack;
  logic [31:0] rd_address;
  logic [7:0]  rd_burstcount;
  logic        rd_read;
  logic        rd_waitrequest = 1'b1;
  logic [31:0] rd_readdata = '0;
  logic        rd_readdatavalid = 1'b0;
  logic        pix_pop = 1'b0;
  logic [23:0] pix_data;
  logic        underflow;
`ifdef LCD_SCANOUT_UNDERFLOW_COUNT_EN
  logic [15:0] underflow_count;
  localparam logic [23:0] UF_PIX = 24'hFF00FF;
`else
  localparam logic [23:0] UF_PIX = 24'h000000;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  lcd_fb_scanout_ctrl #(
    .WIDTH(8), .HEIGHT(2), .BURST_LEN(4), .FIFO_DEPTH(8)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .next_frame       (next_frame),
    .fb_base          (fb_base),
    .swap_req         (swap_req),
    .swap_ack         (swap_ack),
    .rd_address       (rd_address),
    .rd_burstcount    (rd_burstcount),
    .rd_read          (rd_read),
    .rd_waitrequest   (rd_waitrequest),
    .rd_readdata      (rd_readdata),
    .rd_readdatavalid (rd_readdatavalid),
    .pix_pop          (pix_pop),
    .pix_data         (pix_data),
    .underflow        (underflow)
`ifdef LCD_SCANOUT_UNDERFLOW_COUNT_EN
    ,
    .underflow_count  (underflow_count)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rd(input int limit);
    int n = 0;
    while (rd_read !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check("wait_rd_read", rd_read, 1);
  endtask

  task automatic accept_burst(input logic [31:0] exp_addr, input int stall);
    wait_rd(20);
    for (int i = 0; i < stall; i++) begin
      check("stall_addr", rd_address, exp_addr);
      check("stall_read", rd_read, 1);
      tick();
    end
    check("burst_addr", rd_address, exp_addr);
    check("burst_count", rd_burstcount, 8'd4);
    rd_waitrequest = 1'b0;
    tick();
    rd_waitrequest = 1'b1;
  endtask

  task automatic return_beats(input logic [23:0] data0);
    for (int i = 0; i < 4; i++) begin
      rd_readdatavalid = 1'b1;
      rd_readdata = {8'hEE, data0 + 24'(i)};
      tick();
    end
    rd_readdatavalid = 1'b0;
    rd_readdata = '0;
  endtask

  task automatic pop_check(input int n, input logic [23:0] data0);
    for (int i = 0; i < n; i++) begin
      check("pop_data", pix_data, data0 + 24'(i));
      pix_pop = 1'b1;
      tick();
    end
    pix_pop = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_read"}, rd_read, 0);
    check({tag, "_rd_address"}, rd_address, 0);
    check({tag, "_rd_burstcount"}, rd_burstcount, 0);
    check({tag, "_swap_ack"}, swap_ack, 0);
    check({tag, "_underflow"}, underflow, 0);
    check({tag, "_pix_data"}, pix_data, 0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // Swap then frame: four bursts from the new base, first one stalled five cycles.
    fb_base = 32'h1000_0000;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    fb_base = 32'hDEAD_BEEF;
    next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
    check("swap_ack_start", swap_ack, 1);
    check("rd_read_in_start", rd_read, 0);
    tick();
    check("swap_ack_pulse", swap_ack, 0);
    check("first_read_latency", rd_read, 1);
    accept_burst(32'h1000_0000, 5);
    check("one_accept_addr", rd_address, 32'h1000_0010);
    return_beats(24'hA00000);
    pop_check(4, 24'hA00000);
    accept_burst(32'h1000_0010, 0);
    return_beats(24'hA10000);
    pop_check(4, 24'hA10000);
    accept_burst(32'h1000_0020, 0);
    return_beats(24'hA20000);
    pop_check(4, 24'hA20000);
    accept_burst(32'h1000_0030, 0);
    check("drain_no_read", rd_read, 0);
    return_beats(24'hA30000);
    pop_check(4, 24'hA30000);
    repeat (3) tick();
    check("idle_rd_read", rd_read, 0);
    check("idle_burstcount", rd_burstcount, 0);
    check("idle_fifo_empty", pix_data, 0);

    // No pops: credit limits to two bursts until four pixels are consumed.
    next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
    check("no_swap_ack", swap_ack, 0);
    accept_burst(32'h1000_0000, 0);
    return_beats(24'hB00000);
    accept_burst(32'h1000_0010, 0);
    return_beats(24'hB10000);
    for (int i = 0; i < 3; i++) begin
      check("credit_block", rd_read, 0);
      tick();
    end
    pop_check(4, 24'hB00000);
    check("credit_resume", rd_read, 1);
    check("credit_resume_addr", rd_address, 32'h1000_0020);

    // Abort with a burst in flight: beats are discarded, frame restarts at front base.
    accept_burst(32'h1000_0020, 0);
    next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
    check("abort_no_read", rd_read, 0);
    pop_check(4, 24'hB10000);
    check("abort_fifo_empty", pix_data, 0);
    return_beats(24'h5A5A00);
    check("abort_discard", pix_data, 0);
    check("abort_still_no_read", rd_read, 0);
    wait_rd(10);
    check("restart_base", rd_address, 32'h1000_0000);
    check("restart_fifo_empty", pix_data, 0);

    // Underflow: sticky until the next frame's start.
    pix_pop = 1'b1;
    check("underflow_pix", pix_data, 32'(UF_PIX));
    tick();
    pix_pop = 1'b0;
    check("underflow_set", underflow, 1);
`ifdef LCD_SCANOUT_UNDERFLOW_COUNT_EN
    check("underflow_count_1", underflow_count, 1);
`endif
    tick();
    check("underflow_sticky", underflow, 1);
    next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
    check("underflow_held_abort", underflow, 1);
    wait_rd(10);
    check("underflow_cleared", underflow, 0);
`ifdef LCD_SCANOUT_UNDERFLOW_COUNT_EN
    check("underflow_count_clr", underflow_count, 0);
`endif

    // Asynchronous reset mid-fetch drops the pending swap.
    fb_base = 32'h2000_0000;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    accept_burst(32'h1000_0000, 0);
    check("pre_reset_addr", rd_address, 32'h1000_0010);
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick();
    reset_n = 1'b1;
    tick();
    next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
    check("swap_lost", swap_ack, 0);
    tick();
    check("post_reset_read", rd_read, 1);
    check("post_reset_front", rd_address, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
